datamem_arbiter: RTL and testbench

Parametrised N-channel arbiter and request buffer in front of the single-port data memory (`datamem_mem`). It serves the CPU and any number of accelerator channels. Each channel pushes requests into its own FIFO through a valid/ready handshake. Each cycle at most one FIFO head is granted onto the memory port, either round-robin or CPU-priority with a starvation bound, and read data is returned one cycle after issue with a per-channel valid pulse.

---
 rtl/datamem_arbiter_if.sv | 40 ++++
 rtl/datamem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_datamem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datamem_arbiter_if.sv
// datamem_arbiter_if
//   Bundles the requestor-side handshake (req_*/rsp_*) and the memory-side
//   bus (mem_*) of datamem_arbiter.
//   slave  : arbiter view (takes requests and read data, drives the memory port)
//   master : requestor/memory view (drives requests and read data)
//   req_valid/req_ready/req_wrt_en : per-channel handshake and write flag
//   req_addr/req_wrt_data          : packed per-channel address and write data
//   rsp_valid/rsp_data             : one-hot read-response pulse and shared line
//   mem_addr/mem_wrt_data/mem_wrt_en/mem_rd_en/mem_rd_data : memory port
interface datamem_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LINE_W = 512
);
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wrt_data;
  logic [NUM_CH-1:0]        req_wrt_en;
  logic [NUM_CH-1:0]        rsp_valid;
  logic [LINE_W-1:0]        rsp_data;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wrt_data;
  logic                     mem_wrt_en;
  logic                     mem_rd_en;
  logic [LINE_W-1:0]        mem_rd_data;

  modport slave (
    input  req_valid, req_addr, req_wrt_data, req_wrt_en, mem_rd_data,
    output req_ready, rsp_valid, rsp_data,
    output mem_addr, mem_wrt_data, mem_wrt_en, mem_rd_en
  );

  modport master (
    output req_valid, req_addr, req_wrt_data, req_wrt_en, mem_rd_data,
    input  req_ready, rsp_valid, rsp_data,
    input  mem_addr, mem_wrt_data, mem_wrt_en, mem_rd_en
  );
endinterface

// File: rtl/datamem_arbiter.sv
// datamem_arbiter
//   N-channel request buffer and arbiter in front of the single-port data
//   memory. Each channel owns a FIFO filled through a valid/ready handshake;
//   at most one FIFO head per cycle is issued on the memory port, chosen
//   round-robin (PRIO_MODE=0) or CPU-first with a starvation guard
//   (PRIO_MODE=1). Read data returns one cycle after issue with a one-hot
//   rsp_valid pulse.
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-high reset
//   bus : datamem_arbiter_if.slave (request handshake, responses, memory port)
module datamem_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int LINE_W     = 512,
  parameter int FIFO_DEPTH = 4,
  parameter int PRIO_MODE  = 1,
  parameter int MAX_WAIT   = 8
) (
  input  logic            clk,
  input  logic            rst,
  datamem_arbiter_if.slave bus
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              we;
  } entry_t;

  entry_t             fifo_mem [NUM_CH][FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr   [NUM_CH];
  logic [PTR_W:0]     rd_ptr   [NUM_CH];
  entry_t             head     [NUM_CH];
  logic [NUM_CH-1:0]  full;
  logic [NUM_CH-1:0]  empty;
  logic [NUM_CH-1:0]  push;
  logic [NUM_CH-1:0]  pop;

  logic [WAIT_W-1:0]  wait_q [NUM_CH];
  logic [CH_W-1:0]    rr_q;
  logic               grant_vld;
  logic [CH_W-1:0]    grant_ch;
  logic               rr_sel;
  logic [CH_W-1:0]    cand;

  logic               tag_vld;
  logic [CH_W-1:0]    tag_ch;
  logic [NUM_CH-1:0]  rsp_valid_c;

  // Occupancy flags from start-of-cycle pointers; the extra MSB separates
  // full from empty when the index bits coincide.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][PTR_W] != rd_ptr[i][PTR_W]) &&
                 (wr_ptr[i][PTR_W-1:0] == rd_ptr[i][PTR_W-1:0]);
      head[i]  = fifo_mem[i][rd_ptr[i][PTR_W-1:0]];
      push[i]  = bus.req_valid[i] & ~full[i];
    end
  end

  assign bus.req_ready = ~full;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        fifo_mem[i][wr_ptr[i][PTR_W-1:0]] <= '{
          addr: bus.req_addr[i*ADDR_W +: ADDR_W],
          data: bus.req_wrt_data[i*DATA_W +: DATA_W],
          we:   bus.req_wrt_en[i]
        };
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + (PTR_W+1)'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + (PTR_W+1)'(1);
      end
    end
  end

  // Grant selection. In priority mode a saturated waiter beats the CPU, the
  // CPU beats the rest, and the remaining channels share the rr search with
  // channel 0 skipped. rr_sel marks grants that came from the rr search.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    rr_sel    = 1'b0;
    cand      = '0;
    pop       = '0;
    if (PRIO_MODE != 0) begin
      for (int unsigned i = 1; i < NUM_CH; i++) begin
        if (!grant_vld && !empty[i] && (wait_q[i] == WAIT_W'(MAX_WAIT))) begin
          grant_vld = 1'b1;
          grant_ch  = CH_W'(i);
        end
      end
      if (!grant_vld && !empty[0]) begin
        grant_vld = 1'b1;
        grant_ch  = '0;
      end
    end
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = CH_W'((32'(rr_q) + k) % NUM_CH);
      if (!grant_vld && !empty[cand] && ((PRIO_MODE == 0) || (cand != '0))) begin
        grant_vld = 1'b1;
        grant_ch  = cand;
        rr_sel    = 1'b1;
      end
    end
    if (grant_vld) pop[grant_ch] = 1'b1;
  end

  assign bus.mem_addr     = grant_vld ? head[grant_ch].addr : '0;
  assign bus.mem_wrt_data = grant_vld ? head[grant_ch].data : '0;
  assign bus.mem_wrt_en   = grant_vld &  head[grant_ch].we;
  assign bus.mem_rd_en    = grant_vld & ~head[grant_ch].we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= '0;
    end else if (grant_vld && rr_sel) begin
      rr_q <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) wait_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (pop[i] || empty[i]) begin
          wait_q[i] <= '0;
        end else if (wait_q[i] != WAIT_W'(MAX_WAIT)) begin
          wait_q[i] <= wait_q[i] + WAIT_W'(1);
        end
      end
    end
  end

  // Read tag: the memory returns the line one cycle after mem_rd_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= 1'b0;
      tag_ch  <= '0;
    end else begin
      tag_vld <= bus.mem_rd_en;
      tag_ch  <= grant_ch;
    end
  end

  always_comb begin
    rsp_valid_c = '0;
    if (tag_vld) rsp_valid_c[tag_ch] = 1'b1;
  end

  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = tag_vld ? bus.mem_rd_data : '0;

endmodule

// File: tb/tb_datamem_arbiter.sv
// tb_datamem_arbiter
//   Two arbiters (round-robin and CPU-priority, 3 channels, MAX_WAIT=4) run
//   against per-channel request queues, each with its own memory, and are
//   compared every cycle against a queue-based reference model.
module tb_datamem_arbiter;

  localparam int N     = 3;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int LW    = 512;
  localparam int DEPTH = 4;
  localparam int MW    = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          we;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    vld    [2];
  logic [N*AW-1:0] paddr  [2];
  logic [N*DW-1:0] pdata  [2];
  logic [N-1:0]    pwe    [2];
  logic [N-1:0]    rdy    [2];
  logic [N-1:0]    rspv   [2];
  logic [LW-1:0]   rspd   [2];
  logic [LW-1:0]   rd_line[2];
  logic [AW-1:0]   maddr  [2];
  logic [DW-1:0]   mwdata [2];
  logic            mwe    [2];
  logic            mre    [2];

  datamem_arbiter_if #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .LINE_W(LW)) bus0 ();
  datamem_arbiter_if #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .LINE_W(LW)) bus1 ();

  assign bus0.req_valid    = vld[0];
  assign bus0.req_addr     = paddr[0];
  assign bus0.req_wrt_data = pdata[0];
  assign bus0.req_wrt_en   = pwe[0];
  assign bus0.mem_rd_data  = rd_line[0];
  assign rdy[0]    = bus0.req_ready;
  assign rspv[0]   = bus0.rsp_valid;
  assign rspd[0]   = bus0.rsp_data;
  assign maddr[0]  = bus0.mem_addr;
  assign mwdata[0] = bus0.mem_wrt_data;
  assign mwe[0]    = bus0.mem_wrt_en;
  assign mre[0]    = bus0.mem_rd_en;

  assign bus1.req_valid    = vld[1];
  assign bus1.req_addr     = paddr[1];
  assign bus1.req_wrt_data = pdata[1];
  assign bus1.req_wrt_en   = pwe[1];
  assign bus1.mem_rd_data  = rd_line[1];
  assign rdy[1]    = bus1.req_ready;
  assign rspv[1]   = bus1.rsp_valid;
  assign rspd[1]   = bus1.rsp_data;
  assign maddr[1]  = bus1.mem_addr;
  assign mwdata[1] = bus1.mem_wrt_data;
  assign mwe[1]    = bus1.mem_wrt_en;
  assign mre[1]    = bus1.mem_rd_en;

  datamem_arbiter #(
    .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .LINE_W(LW),
    .FIFO_DEPTH(DEPTH), .PRIO_MODE(0), .MAX_WAIT(MW)
  ) dut_rr (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  datamem_arbiter #(
    .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .LINE_W(LW),
    .FIFO_DEPTH(DEPTH), .PRIO_MODE(1), .MAX_WAIT(MW)
  ) dut_prio (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a, input logic [DW-1:0] w);
    line_of = {{15{{16'hC0DE, a}}}, w};
  endfunction

  function automatic logic [DW-1:0] base_word(input int i);
    base_word = 32'h5A00_0000 | DW'(i);
  endfunction

  // Behavioural memory attached to each DUT, driven only by the DUT's port.
  logic [DW-1:0] hw_mem [2][256];
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (mem_init) begin
        for (int i = 0; i < 256; i++) hw_mem[m][i] <= base_word(i);
        rd_line[m] <= '0;
      end else begin
        if (mwe[m]) hw_mem[m][maddr[m][7:0]] <= mwdata[m];
        if (mre[m]) rd_line[m] <= line_of(maddr[m], hw_mem[m][maddr[m][7:0]]);
      end
    end
  end

  // Reference model state.
  req_t          q     [2][N][$];
  req_t          stim  [2][N][$];
  int            wt    [2][N];
  int            rr    [2];
  logic          tag_v [2];
  int            tag_ch[2];
  logic [LW-1:0] tag_line[2];
  logic [DW-1:0] ref_mem [2][256];
  int            g     [2];
  logic          rule3 [2];
  logic [N-1:0]  acc   [2];
  logic          gaps = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Channel to serve this cycle for model m (0 = round-robin, 1 = priority).
  function automatic int pick(input int m, output logic r3);
    r3 = 1'b0;
    if (m == 1) begin
      for (int c = 1; c < N; c++)
        if (q[m][c].size() > 0 && wt[m][c] >= MW) return c;
      if (q[m][0].size() > 0) return 0;
    end
    for (int k = 0; k < N; k++) begin
      int c;
      c = (rr[m] + k) % N;
      if (m == 1 && c == 0) continue;
      if (q[m][c].size() > 0) begin
        r3 = 1'b1;
        return c;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < N; c++) begin
        q[m][c].delete();
        wt[m][c] = 0;
      end
      rr[m]    = 0;
      tag_v[m] = 1'b0;
      tag_ch[m] = 0;
      tag_line[m] = '0;
    end
  endtask

  task automatic drive();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < N; c++) begin
        if (stim[m][c].size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
          vld[m][c]            = 1'b1;
          paddr[m][c*AW +: AW] = stim[m][c][0].addr;
          pdata[m][c*DW +: DW] = stim[m][c][0].data;
          pwe[m][c]            = stim[m][c][0].we;
        end else begin
          vld[m][c]            = 1'b0;
          paddr[m][c*AW +: AW] = AW'($urandom);
          pdata[m][c*DW +: DW] = $urandom;
          pwe[m][c]            = 1'($urandom_range(0, 1));
        end
      end
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      logic [N-1:0]  er;
      logic [N-1:0]  erv;
      logic          r3;
      req_t          h;
      logic [1:0]    es;
      er = '0;
      for (int c = 0; c < N; c++) er[c] = (q[m][c].size() < DEPTH);
      g[m] = pick(m, r3);
      rule3[m] = r3;
      acc[m] = rst ? '0 : (vld[m] & er);
      h  = '0;
      es = 2'b00;
      if (g[m] >= 0) begin
        h  = q[m][g[m]][0];
        es = {h.we, ~h.we};
      end
      erv = '0;
      if (tag_v[m]) erv[tag_ch[m]] = 1'b1;
      check($sformatf("req_ready%0d", m), LW'(rdy[m]), LW'(er));
      check($sformatf("mem_strobes%0d", m), LW'({mwe[m], mre[m]}), LW'(es));
      check($sformatf("mem_addr%0d", m), LW'(maddr[m]), LW'(h.addr));
      check($sformatf("mem_wrt_data%0d", m), LW'(mwdata[m]), LW'(h.data));
      check($sformatf("rsp_valid%0d", m), LW'(rspv[m]), LW'(erv));
      check($sformatf("rsp_data%0d", m), rspd[m], tag_v[m] ? tag_line[m] : '0);
    end
  endtask

  task automatic update();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < N; c++) begin
        if (c == g[m] || q[m][c].size() == 0) wt[m][c] = 0;
        else if (wt[m][c] < MW)               wt[m][c]++;
      end
      tag_v[m] = 1'b0;
      if (g[m] >= 0) begin
        req_t h;
        h = q[m][g[m]].pop_front();
        if (h.we) begin
          ref_mem[m][h.addr[7:0]] = h.data;
        end else begin
          tag_v[m]    = 1'b1;
          tag_ch[m]   = g[m];
          tag_line[m] = line_of(h.addr, ref_mem[m][h.addr[7:0]]);
        end
        if (m == 0 || rule3[m]) rr[m] = (g[m] + 1) % N;
      end
      for (int c = 0; c < N; c++)
        if (acc[m][c]) q[m][c].push_back(stim[m][c].pop_front());
    end
  endtask

  // Entered 1 ns after a rising edge; leaves 1 ns after the next one.
  task automatic cycle(input logic r);
    rst = r;
    if (r) model_reset();
    drive();
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (!rst) update();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle(1'b0);
  endtask

  task automatic add(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we);
    req_t r;
    r = '{addr: a, data: d, we: we};
    stim[0][c].push_back(r);
    stim[1][c].push_back(r);
  endtask

  function automatic logic busy();
    busy = 1'b0;
    for (int m = 0; m < 2; m++) begin
      if (tag_v[m]) busy = 1'b1;
      for (int c = 0; c < N; c++)
        if (q[m][c].size() > 0 || stim[m][c].size() > 0) busy = 1'b1;
    end
  endfunction

  task automatic drain();
    int guard;
    guard = 0;
    while (busy() && guard < 200) begin
      cycle(1'b0);
      guard++;
    end
    check("drain_timeout", LW'(guard >= 200), '0);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      vld[m] = '0; paddr[m] = '0; pdata[m] = '0; pwe[m] = '0;
      for (int i = 0; i < 256; i++) ref_mem[m][i] = base_word(i);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    cycle(1'b1);
    cycle(1'b1);

    // CPU read
    add(0, 16'h0010, '0, 1'b0);
    run(4);

    // two reads preloaded per channel
    for (int c = 0; c < N; c++) begin
      add(c, 16'(8'h20 + c), '0, 1'b0);
      add(c, 16'(8'h28 + c), '0, 1'b0);
    end
    drain();

    // continuous CPU traffic, one write on ch1 must get through
    for (int i = 0; i < 10; i++) add(0, 16'(8'h30 + i), '0, 1'b0);
    add(1, 16'h0050, 32'h1234_5678, 1'b1);
    drain();

    // ch1 overfills its FIFO behind a busy CPU
    for (int i = 0; i < 16; i++) add(0, 16'(8'h60 + i), $urandom, 1'b1);
    for (int i = 0; i < 5; i++)  add(1, 16'(8'h60 + i), '0, 1'b0);
    drain();

    // read-after-write on ch1
    add(1, 16'h0040, 32'hDEAD_BEEF, 1'b1);
    add(1, 16'h0040, '0, 1'b0);
    drain();

    // reset lands in the cycle the read is issued
    add(2, 16'h0020, '0, 1'b0);
    cycle(1'b0);
    cycle(1'b1);
    cycle(1'b0);
    run(3);

    // random traffic with valid gaps and occasional resets
    gaps = 1'b1;
    for (int t = 0; t < 800; t++) begin
      for (int c = 0; c < N; c++) begin
        if (stim[0][c].size() < 3 && $urandom_range(0, 2) == 0)
          add(c, 16'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
        if (stim[1][c].size() < 3 && $urandom_range(0, 2) == 0) begin
          req_t r;
          r = '{addr: 16'($urandom_range(0, 31)), data: $urandom, we: 1'($urandom_range(0, 1))};
          stim[1][c].push_back(r);
        end
      end
      cycle(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end
    gaps = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
